// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-side memory responder for the pipelined core. Stores are posted into a
//   small circular write buffer and drained to a slow single-port SRAM over a
//   req/ack handshake. Loads are answered from the buffer when the word is
//   present there. Otherwise the FSM performs an SRAM read and Stall is held
//   until the data is returned.
//
// Ports
//   clk         core clock, rising edge
//   reset       asynchronous, active-low
//   MemWrite    store request
//   MemRead     load request (ignored when MemWrite is also high)
//   DataAdr     byte address, word granularity ([1:0] ignored)
//   WriteData   store data
//   ReadData    load data, valid when MemRead & !Stall
//   Stall       core holds MEM-stage inputs while high
//   sram_req    SRAM request
//   sram_we     SRAM write enable (valid with sram_req)
//   sram_addr   SRAM word address
//   sram_wdata  SRAM write data
//   sram_rdata  SRAM read data, valid with sram_ack
//   sram_ack    one-cycle SRAM completion pulse
//
// FSM states
//   state  | meaning
//   S_IDLE | no SRAM access; pick a load miss first, else drain the buffer
//   S_WR   | writing the head buffer entry to SRAM, waiting for ack
//   S_RD   | reading the missed load word from SRAM, waiting for ack
//   S_RESP | one cycle presenting the SRAM read data to the core
module data_mem_responder #(
  parameter int WB_DEPTH = 4,
  parameter int DATA_W   = 32,
  parameter int SRAM_AW  = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic [31:0]        DataAdr,
  input  logic [DATA_W-1:0]  WriteData,
  output logic [DATA_W-1:0]  ReadData,
  output logic               Stall,
  output logic               sram_req,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata,
  input  logic               sram_ack
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [SRAM_AW-1:0] r_wb_addr [WB_DEPTH];
  logic [DATA_W-1:0]  r_wb_data [WB_DEPTH];
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_sram_req;
  logic               r_sram_we;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [DATA_W-1:0]  r_sram_wdata;

  logic [SRAM_AW-1:0] w_word_adr;
  logic               w_full;
  logic               w_load;
  logic               w_enq;
  logic               w_deq;
  logic               w_hit;
  logic [DATA_W-1:0]  w_hit_data;
  logic [PTR_W-1:0]   w_scan_idx;
  logic               w_unused_adr;

  assign w_word_adr   = DataAdr[SRAM_AW+1:2];
  assign w_unused_adr = &{1'b0, DataAdr[1:0]};
  assign w_full       = (r_count == CNT_W'(WB_DEPTH));
  // A simultaneous load and store is treated purely as a store.
  assign w_load       = MemRead & ~MemWrite;
  assign w_enq        = MemWrite & ~w_full;
  assign w_deq        = (r_state == S_WR) & sram_ack;

  // Scan from oldest to newest so the newest matching entry overrides older ones.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_scan_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_scan_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_wb_addr[w_scan_idx] == w_word_adr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_wb_data[w_scan_idx];
      end
    end
  end

  assign Stall    = (MemWrite & w_full) | (w_load & ~w_hit & (r_state != S_RESP));
  assign ReadData = !w_load ? '0 : (w_hit ? w_hit_data : r_rd_data);

  assign sram_req   = r_sram_req;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

  // Buffer payload needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_wb_addr[r_tail] <= w_word_adr;
      r_wb_data[r_tail] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // SRAM outputs are loaded on the transition into WR/RD; the core holds
  // DataAdr stable while stalled, so capturing it once is sufficient.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rd_data    <= '0;
      r_sram_req   <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load && !w_hit) begin
            r_state     <= S_RD;
            r_sram_req  <= 1'b1;
            r_sram_we   <= 1'b0;
            r_sram_addr <= w_word_adr;
          end else if (r_count != '0) begin
            r_state      <= S_WR;
            r_sram_req   <= 1'b1;
            r_sram_we    <= 1'b1;
            r_sram_addr  <= r_wb_addr[r_head];
            r_sram_wdata <= r_wb_data[r_head];
          end
        end
        S_WR: begin
          if (sram_ack) begin
            r_state    <= S_IDLE;
            r_sram_req <= 1'b0;
            r_sram_we  <= 1'b0;
          end
        end
        S_RD: begin
          if (sram_ack) begin
            r_state    <= S_RESP;
            r_rd_data  <= sram_rdata;
            r_sram_req <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder with a behavioural slow SRAM whose
//   ack latency is adjustable per scenario. Expected values are hand-computed.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        Stall;
  logic        sram_req, sram_we, sram_ack;
  logic [29:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.WB_DEPTH(4), .DATA_W(32), .SRAM_AW(30)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
  } txn_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_lat = 1;
  int          wait_cnt = 0;
  int          addr_viol = 0;
  txn_t        log_q[$];
  logic [31:0] mem [logic [29:0]];
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [29:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  // Slow SRAM: ack arrives ack_lat cycles after the first request cycle.
  always @(negedge clk) begin
    if (sram_req && prev_req && !prev_ack &&
        (sram_addr != prev_addr || sram_we != prev_we || (sram_we && sram_wdata != prev_wdata)))
      addr_viol++;
    prev_req   = sram_req;
    prev_ack   = sram_ack;
    prev_we    = sram_we;
    prev_addr  = sram_addr;
    prev_wdata = sram_wdata;
    if (!reset || !sram_req || sram_ack) begin
      sram_ack = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt == ack_lat) begin
      sram_ack = 1'b1;
      if (sram_we) begin
        mem[sram_addr] = sram_wdata;
        log_q.push_back('{1'b1, sram_addr, sram_wdata});
      end else begin
        sram_rdata = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
        log_q.push_back('{1'b0, sram_addr, sram_rdata});
      end
    end else begin
      wait_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    MemWrite = 1'b1; MemRead = 1'b0; DataAdr = a; WriteData = d; stalls = 0;
    @(negedge clk);
    while (Stall && stalls < 60) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] data, output int stalls);
    MemRead = 1'b1; MemWrite = 1'b0; DataAdr = a; stalls = 0;
    @(negedge clk);
    while (Stall && stalls < 60) begin
      stalls++;
      @(negedge clk);
    end
    data = ReadData;
    @(posedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 300) begin
      @(negedge clk);
      quiet = sram_req ? 0 : quiet + 1;
      n++;
    end
    check_eq(tag, 64'(quiet >= 3), 64'd1);
    @(posedge clk); #1;
  endtask

  int          st;
  logic [31:0] rd;
  int          n_req;
  int          n_wait;

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
    sram_ack = 1'b0; sram_rdata = '0;
    #2;
    check_eq("rst_req", 64'(sram_req), 64'd0);
    check_eq("rst_stall", 64'(Stall), 64'd0);
    check_eq("rst_rdata", 64'(ReadData), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset in the middle of a write abandons it and empties the buffer.
    ack_lat = 5;
    store(32'h80, 32'h9, st);
    n_wait = 0;
    @(negedge clk);
    while (!(sram_req && sram_we) && n_wait < 10) begin
      n_wait++;
      @(negedge clk);
    end
    check_eq("t1_wr_started", 64'(sram_req && sram_we), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t1_req_in_reset", 64'(sram_req), 64'd0);
    check_eq("t1_stall_in_reset", 64'(Stall), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n_req = 0;
    repeat (6) begin
      @(negedge clk);
      if (sram_req) n_req++;
    end
    check_eq("t1_no_req_after", 64'(n_req), 64'd0);
    @(posedge clk); #1;
    log_q.delete();
    load(32'h80, rd, st);
    check_eq("t1_load_stalls", 64'(st), 64'd7);
    check_eq("t1_load_data", 64'(rd), 64'd0);
    drain("t1_drain");

    // Store then immediate load of the same word: forwarded, no SRAM read.
    ack_lat = 1;
    log_q.delete();
    store(32'h100, 32'hDEADBEEF, st);
    check_eq("t2_store_stalls", 64'(st), 64'd0);
    load(32'h100, rd, st);
    check_eq("t2_hit_stalls", 64'(st), 64'd0);
    check_eq("t2_hit_data", 64'(rd), 64'hDEADBEEF);
    drain("t2_drain");
    check_eq("t2_txn_count", 64'(log_q.size()), 64'd1);
    check_eq("t2_txn_we", 64'(log_q[0].we), 64'd1);
    check_eq("t2_txn_addr", 64'(log_q[0].addr), 64'h40);

    // Two stores to one word: newest forwarded, both written in order.
    log_q.delete();
    store(32'h40, 32'h1, st);
    store(32'h40, 32'h2, st);
    load(32'h40, rd, st);
    check_eq("t3_hit_stalls", 64'(st), 64'd0);
    check_eq("t3_hit_data", 64'(rd), 64'h2);
    drain("t3_drain");
    check_eq("t3_txn_count", 64'(log_q.size()), 64'd2);
    check_eq("t3_first_data", 64'(log_q[0].data), 64'h1);
    check_eq("t3_second_data", 64'(log_q[1].data), 64'h2);
    check_eq("t3_addr", 64'(log_q[1].addr), 64'h10);

    // Buffer full: fifth back-to-back store stalls until the first ack.
    ack_lat = 3;
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      store(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), st);
      check_eq($sformatf("t4_stalls_%0d", i), 64'(st), (i == 4) ? 64'd2 : 64'd0);
    end
    drain("t4_drain");
    check_eq("t4_txn_count", 64'(log_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_addr_%0d", i), 64'(log_q[i].addr), 64'h400 + 64'(i));
      check_eq($sformatf("t4_data_%0d", i), 64'(log_q[i].data), 64'hA0 + 64'(i));
    end

    // Load miss from IDLE with 2-cycle SRAM latency.
    ack_lat = 2;
    mem[30'h80] = 32'h12345678;
    log_q.delete();
    load(32'h200, rd, st);
    check_eq("t5_stalls", 64'(st), 64'd4);
    check_eq("t5_data", 64'(rd), 64'h12345678);

    // Load miss arriving during a write waits for that write first.
    ack_lat = 3;
    mem[30'h140] = 32'h55;
    drain("t6_pre_drain");
    log_q.delete();
    store(32'h300, 32'hAA, st);
    @(posedge clk); #1;
    load(32'h500, rd, st);
    check_eq("t6_stalls", 64'(st), 64'd9);
    check_eq("t6_data", 64'(rd), 64'h55);
    check_eq("t6_first_is_wr", 64'(log_q[0].we), 64'd1);
    check_eq("t6_first_addr", 64'(log_q[0].addr), 64'hC0);
    check_eq("t6_second_is_rd", 64'(log_q[1].we), 64'd0);
    check_eq("t6_second_addr", 64'(log_q[1].addr), 64'h140);

    // Load and store together: store only, no read, no stall.
    drain("t7_pre_drain");
    log_q.delete();
    MemRead = 1'b1; MemWrite = 1'b1; DataAdr = 32'h600; WriteData = 32'h77;
    @(negedge clk);
    check_eq("t7_stall", 64'(Stall), 64'd0);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    drain("t7_drain");
    check_eq("t7_txn_count", 64'(log_q.size()), 64'd1);
    check_eq("t7_txn_we", 64'(log_q[0].we), 64'd1);
    check_eq("t7_txn_data", 64'(log_q[0].data), 64'h77);

    check_eq("sram_addr_stable", 64'(addr_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
